// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - HI/LO multiply/divide sequencer (optional MADD/MSUB via HILO_MADD_EN)
module hilo_mdu_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic        hi_we,
    output logic [31:0] hi_wdata,
    output logic        lo_we,
    output logic [31:0] lo_wdata,
    output logic        busy,
    output logic        stall_req
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_SUB  = 2'd2;
    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 2);

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sgn_q;
    logic [1:0]  acc_mode_q;
    logic [63:0] acc_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic        dz_q;
    logic        hi_we_q;
    logic        lo_we_q;
    logic [31:0] hi_wdata_q;
    logic [31:0] lo_wdata_q;

    logic        dec_mul;
    logic        dec_div;
    logic        dec_mthi;
    logic        dec_mtlo;
    logic        dec_sgn;
    logic [1:0]  dec_acc;

    // Decode the presented op code into operation class and signedness
    always_comb begin
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        dec_sgn  = 1'b0;
        dec_acc  = ACC_NONE;
        case (op_code)
            4'b0000: begin dec_mul = 1'b1; dec_sgn = 1'b1; end
            4'b0001: dec_mul = 1'b1;
            4'b0010: begin dec_div = 1'b1; dec_sgn = 1'b1; end
            4'b0011: dec_div = 1'b1;
            4'b0100: dec_mthi = 1'b1;
            4'b0101: dec_mtlo = 1'b1;
`ifdef HILO_MADD_EN
            4'b0110: begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_ADD; end
            4'b0111: begin dec_mul = 1'b1; dec_acc = ACC_ADD; end
            4'b1000: begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_SUB; end
            4'b1001: begin dec_mul = 1'b1; dec_acc = ACC_SUB; end
`endif
            default: ;
        endcase
    end

    logic        accept;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        src_sgn;
    logic [1:0]  src_acc_mode;
    logic [63:0] src_acc;
    logic [63:0] prod;
    logic [63:0] mac_result;

    assign accept = op_valid && op_ready && !flush;

    // Multiply path reads live operands on the accept cycle (single-cycle latency) and latched ones afterwards
    always_comb begin
        src_a        = (state == S_IDLE) ? op_a : a_q;
        src_b        = (state == S_IDLE) ? op_b : b_q;
        src_sgn      = (state == S_IDLE) ? dec_sgn : sgn_q;
        src_acc_mode = (state == S_IDLE) ? dec_acc : acc_mode_q;
        src_acc      = (state == S_IDLE) ? {hi_cur, lo_cur} : acc_q;
        prod = {{32{src_sgn & src_a[31]}}, src_a} * {{32{src_sgn & src_b[31]}}, src_b};
        case (src_acc_mode)
            ACC_ADD: mac_result = src_acc + prod;
            ACC_SUB: mac_result = src_acc - prod;
            default: mac_result = prod;
        endcase
    end

    logic [32:0] r_sh;
    logic [32:0] r_diff;
    logic        fits;
    logic [31:0] r_nx;
    logic [31:0] q_nx;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // One restoring-divide step on magnitudes plus final sign fix-up
    always_comb begin
        r_sh   = {rem_q, quo_q[31]};
        r_diff = r_sh - {1'b0, dvs_q};
        fits   = ~r_diff[32];
        r_nx   = fits ? r_diff[31:0] : r_sh[31:0];
        q_nx   = {quo_q[30:0], fits};
        q_fix  = neg_q_q ? (32'd0 - q_nx) : q_nx;
        r_fix  = neg_r_q ? (32'd0 - r_nx) : r_nx;
        a_mag  = (dec_sgn && op_a[31]) ? (32'd0 - op_a) : op_a;
        b_mag  = (dec_sgn && op_b[31]) ? (32'd0 - op_b) : op_b;
    end

    // Sequencer: accept, iterate, write back; flush abandons the op without a write
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 6'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            sgn_q      <= 1'b0;
            acc_mode_q <= ACC_NONE;
            acc_q      <= 64'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dz_q       <= 1'b0;
            hi_we_q    <= 1'b0;
            lo_we_q    <= 1'b0;
            hi_wdata_q <= 32'd0;
            lo_wdata_q <= 32'd0;
        end else begin
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        sgn_q      <= dec_sgn;
                        acc_mode_q <= dec_acc;
                        acc_q      <= {hi_cur, lo_cur};
                        cnt        <= 6'd0;
                        if (dec_mul) begin
                            if (MUL_CYCLES == 1) begin
                                state      <= S_WB;
                                hi_we_q    <= 1'b1;
                                lo_we_q    <= 1'b1;
                                hi_wdata_q <= mac_result[63:32];
                                lo_wdata_q <= mac_result[31:0];
                            end else begin
                                state <= S_MUL;
                            end
                        end else if (dec_div) begin
                            state   <= S_DIV;
                            rem_q   <= 32'd0;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            neg_q_q <= dec_sgn & (op_a[31] ^ op_b[31]);
                            neg_r_q <= dec_sgn & op_a[31];
                            dz_q    <= (op_b == 32'd0);
                        end else begin
                            state <= S_WB;
                            if (dec_mthi) begin
                                hi_we_q    <= 1'b1;
                                hi_wdata_q <= op_a;
                            end
                            if (dec_mtlo) begin
                                lo_we_q    <= 1'b1;
                                lo_wdata_q <= op_a;
                            end
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (cnt == MUL_LAST) begin
                        state      <= S_WB;
                        hi_we_q    <= 1'b1;
                        lo_we_q    <= 1'b1;
                        hi_wdata_q <= mac_result[63:32];
                        lo_wdata_q <= mac_result[31:0];
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem_q <= r_nx;
                        quo_q <= q_nx;
                        cnt   <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state      <= S_WB;
                            hi_we_q    <= 1'b1;
                            lo_we_q    <= 1'b1;
                            hi_wdata_q <= dz_q ? a_q : r_fix;
                            lo_wdata_q <= dz_q ? 32'hFFFF_FFFF : q_fix;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A flush or reset landing on the write cycle must still kill the pulse
    assign hi_we     = hi_we_q & ~flush & rst;
    assign lo_we     = lo_we_q & ~flush & rst;
    assign hi_wdata  = hi_wdata_q;
    assign lo_wdata  = lo_wdata_q;
    assign busy      = (state != S_IDLE);
    assign op_ready  = (state == S_IDLE) && rst;
    assign stall_req = busy | (op_valid & ~op_ready);

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb/tb_hilo_mdu_ctrl.sv - scoreboard bench for hilo_mdu_ctrl
module tb_hilo_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic [31:0] hi_cur;
    logic [31:0] lo_cur;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        busy;
    logic        stall_req;

    hilo_mdu_ctrl #(.MUL_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_a(op_a), .op_b(op_b), .flush(flush),
        .hi_cur(hi_cur), .lo_cur(lo_cur), .hi_we(hi_we), .hi_wdata(hi_wdata),
        .lo_we(lo_we), .lo_wdata(lo_wdata), .busy(busy), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hw;
        logic        lw;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [31:0] mon_hi;
    logic [31:0] mon_lo;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_exp(logic hw, logic lw, logic [31:0] hi, logic [31:0] lo, int c);
        exp_t e;
        e.hw = hw; e.lw = lw; e.hi = hw ? hi : 32'h0; e.lo = lw ? lo : 32'h0; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    function automatic logic [63:0] mul_model(logic [31:0] a, logic [31:0] b, bit sg);
        longint sa, sb;
        longint unsigned ua, ub;
        if (sg) begin
            sa = $signed(a); sb = $signed(b);
            return sa * sb;
        end
        ua = a; ub = b;
        return ua * ub;
    endfunction

    function automatic logic [63:0] div_model(logic [31:0] a, logic [31:0] b, bit sg);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sg) begin
            sa = $signed(a); sb = $signed(b);
            q = sa / sb; r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        ua = a; ub = b;
        uq = ua / ub; ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // Scoreboard: every write pulse must match the oldest expected write, including its cycle
    always begin
        @(negedge clk);
        #2;
        if (hi_we === 1'b1 || lo_we === 1'b1) begin
            n_cmp++;
            mon_hi = hi_we ? hi_wdata : 32'h0;
            mon_lo = lo_we ? lo_wdata : 32'h0;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write got hi_we=%b lo_we=%b hi=%h lo=%h cyc=%0d, required no write",
                         hi_we, lo_we, mon_hi, mon_lo, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({hi_we, lo_we, mon_hi, mon_lo, cyc} !== {mon_e.hw, mon_e.lw, mon_e.hi, mon_e.lo, mon_e.cyc}) begin
                    n_err++;
                    $display("FAIL write_check got we=%b%b hi=%h lo=%h cyc=%0d, required we=%b%b hi=%h lo=%h cyc=%0d",
                             hi_we, lo_we, mon_hi, mon_lo, cyc, mon_e.hw, mon_e.lw, mon_e.hi, mon_e.lo, mon_e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, output int t);
        int w;
        w = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (w >= 200) begin
            n_err++;
            $display("FAIL issue_timeout got op_ready=%b, required 1", op_ready);
        end
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
        t = cyc;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || op_ready !== 1'b1) && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending writes, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; op_valid = 1'b0; flush = 1'b0; op_code = 4'd0;
        op_a = 32'd0; op_b = 32'd0; hi_cur = 32'd0; lo_cur = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({op_ready, busy, hi_we, lo_we, stall_req, hi_wdata, lo_wdata} !== 69'd0) begin
            n_err++;
            $display("FAIL reset_state got rdy=%b busy=%b we=%b%b stall=%b hi=%h lo=%h, required all zero",
                     op_ready, busy, hi_we, lo_we, stall_req, hi_wdata, lo_wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got rdy=%b busy=%b, required rdy=1 busy=0", op_ready, busy);
        end
    endtask

    task automatic test_mult();
        int t;
        logic [31:0] a, b;
        logic [63:0] p;
        issue(4'b0000, 32'hFFFF_FFFE, 32'd3, t);
        push_exp(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, t + 2);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_t1 got %b, required 1", busy); end
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL mult_busy_t2 got %b, required 1", busy); end
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mult_done_t3 got busy=%b rdy=%b, required busy=0 rdy=1", busy, op_ready);
        end
        issue(4'b0001, 32'hFFFF_FFFE, 32'd3, t);
        push_exp(1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA, t + 2);
        drain();
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            issue(4'(i % 2), a, b, t);
            p = mul_model(a, b, (i % 2) == 0);
            push_exp(1'b1, 1'b1, p[63:32], p[31:0], t + 2);
        end
        drain();
    endtask

    task automatic test_div();
        int t;
        logic [31:0] a, b;
        logic [63:0] r;
        issue(4'b0010, 32'hFFFF_FFF9, 32'd2, t);
        push_exp(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, t + 33);
        drain();
        issue(4'b0011, 32'd100, 32'd7, t);
        push_exp(1'b1, 1'b1, 32'd2, 32'd14, t + 33);
        drain();
        issue(4'b0010, 32'd5, 32'd0, t);
        push_exp(1'b1, 1'b1, 32'd5, 32'hFFFF_FFFF, t + 33);
        drain();
        issue(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, t);
        push_exp(1'b1, 1'b1, 32'd0, 32'h8000_0000, t + 33);
        drain();
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            issue((i % 2 == 0) ? 4'b0010 : 4'b0011, a, b, t);
            r = div_model(a, b, (i % 2) == 0);
            push_exp(1'b1, 1'b1, r[63:32], r[31:0], t + 33);
            drain();
        end
    endtask

    task automatic test_move();
        int t;
        issue(4'b0100, 32'hA5A5_A5A5, 32'd0, t);
        push_exp(1'b1, 1'b0, 32'hA5A5_A5A5, 32'd0, t + 1);
        issue(4'b0101, 32'h0000_1234, 32'd0, t);
        push_exp(1'b0, 1'b1, 32'd0, 32'h0000_1234, t + 1);
        drain();
        issue(4'b1111, 32'hDEAD_BEEF, 32'd1, t);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL illegal_busy got %b, required 1", busy); end
        @(negedge clk); #1;
        n_cmp++;
        if (op_ready !== 1'b1) begin n_err++; $display("FAIL illegal_ready got %b, required 1", op_ready); end
        drain();
    endtask

    task automatic test_flush();
        int t;
        issue(4'b0011, 32'd100, 32'd7, t);
        while (cyc < t + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || cyc !== t + 11) begin
            n_err++;
            $display("FAIL flush_div got rdy=%b busy=%b cyc=%0d, required rdy=1 busy=0 cyc=%0d", op_ready, busy, cyc, t + 11);
        end
        repeat (40) @(negedge clk);
        issue(4'b0101, 32'h0000_1234, 32'd0, t);
        push_exp(1'b0, 1'b1, 32'd0, 32'h0000_1234, t + 1);
        drain();
        issue(4'b0100, 32'h1111_2222, 32'd0, t);
        flush = 1'b1;
        #1;
        n_cmp++;
        if (hi_we !== 1'b0) begin n_err++; $display("FAIL flush_wb_pulse got hi_we=%b, required 0", hi_we); end
        @(negedge clk);
        flush = 1'b0;
        op_valid = 1'b1; op_code = 4'b0100; op_a = 32'h3333_4444; flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_idle_block got busy=%b rdy=%b, required busy=0 rdy=1", busy, op_ready);
        end
        repeat (3) @(negedge clk);
        drain();
    endtask

    task automatic test_madd();
        int t;
        hi_cur = 32'd0; lo_cur = 32'hFFFF_FFFF;
        issue(4'b0111, 32'd1, 32'd1, t);
        hi_cur = $urandom; lo_cur = $urandom;
`ifdef HILO_MADD_EN
        push_exp(1'b1, 1'b1, 32'd1, 32'd0, t + 2);
        drain();
        hi_cur = 32'd0; lo_cur = 32'd5;
        issue(4'b1000, 32'd2, 32'd3, t);
        hi_cur = $urandom; lo_cur = $urandom;
        push_exp(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t + 2);
`else
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL madd_illegal_busy got %b, required 1", busy); end
        @(negedge clk); #1;
        n_cmp++;
        if (op_ready !== 1'b1 || cyc !== t + 2) begin
            n_err++;
            $display("FAIL madd_illegal_ready got rdy=%b cyc=%0d, required rdy=1 cyc=%0d", op_ready, cyc, t + 2);
        end
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        int t, t2, w;
        issue(4'b0011, 32'd100, 32'd7, t);
        push_exp(1'b1, 1'b1, 32'd2, 32'd14, t + 33);
        op_valid = 1'b1; op_code = 4'b0100; op_a = 32'hA5A5_A5A5; op_b = 32'd0;
        w = 0;
        while (op_ready !== 1'b1 && w < 60) begin
            #1;
            n_cmp++;
            if (stall_req !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_stall got stall_req=%b at cyc=%0d, required 1", stall_req, cyc);
            end
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (cyc !== t + 34) begin
            n_err++;
            $display("FAIL b2b_ready_cycle got cyc=%0d, required %0d", cyc, t + 34);
        end
        t2 = cyc;
        push_exp(1'b1, 1'b0, 32'hA5A5_A5A5, 32'd0, t2 + 1);
        @(negedge clk);
        op_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        int t;
        issue(4'b0010, 32'd1000, 32'd3, t);
        while (cyc < t + 5) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (op_ready !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_outputs got rdy=%b we=%b%b, required rdy=0 we=00", op_ready, hi_we, lo_we);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi_wdata !== 32'd0 || lo_wdata !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_state got busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi_wdata, lo_wdata);
        end
        repeat (40) @(negedge clk);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_flush();
        test_madd();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Multiply/divide sequencer that owns all writes into the HI/LO register pair (hilo_reg).
- Accepts one MDU op at a time from the EX stage and runs it: pipelined multiply, 32-iteration restoring divide, or a direct MTHI/MTLO move.
- Drives hilo_reg's hi_we/hi_i/lo_we/lo_i and raises a stall request to the pipeline while an op is in flight.
- Supports cancellation on exception flush.

Parameters:
- MUL_CYCLES, 2: multiply latency in cycles, from accept to write pulse; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low; state is reset on the clk edge where rst==0
- op_valid  in  1  EX stage presents an MDU op
- op_ready  out  1  controller can accept an op this cycle
- op_code  in  4  operation code (encoding below)
- op_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- op_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  exception flush; cancels the in-flight op
- hi_cur  in  32  current HI value, from hilo_reg hi_o
- lo_cur  in  32  current LO value, from hilo_reg lo_o
- hi_we  out  1  HI write enable, one-cycle pulse
- hi_wdata  out  32  HI write data
- lo_we  out  1  LO write enable, one-cycle pulse
- lo_wdata  out  32  LO write data
- busy  out  1  an op is in flight
- stall_req  out  1  busy | (op_valid & ~op_ready)

Behaviour:
- op_code encoding:
  - 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MTHI, 0101 MTLO
  - 0110 MADD, 0111 MADDU, 1000 MSUB, 1001 MSUBU
  - Any other code is accepted and retired in 1 cycle with no write.
- Reset (rst==0): state=IDLE; busy=0; op_ready=0; hi_we=lo_we=0; hi_wdata=lo_wdata=0; divider registers cleared.
- op_ready=1 only in IDLE and when rst==1. An op is accepted on a cycle with op_valid & op_ready & ~flush. Operands are latched on accept.
- States: IDLE, MUL, DIV, WB.
  - IDLE -> MUL on accepted mul/madd/msub.
  - IDLE -> DIV on accepted div.
  - IDLE -> WB on accepted MTHI/MTLO/illegal.
  - MUL -> WB after MUL_CYCLES-1 cycles in MUL.
  - DIV -> WB after 32 iterations.
  - WB -> IDLE.
- Write timing: outputs are registered. With the accept edge at cycle T, the write pulse is asserted:
  - MTHI/MTLO/illegal: cycle T+1.
  - MUL: cycle T+MUL_CYCLES.
  - DIV: cycle T+33.
- busy=1 from T+1 through the write cycle. op_ready returns to 1 the cycle after the write pulse.
- MTHI: hi_we=1, hi_wdata=op_a, lo_we=0. MTLO is symmetric.
- MULT/MULTU: 64-bit signed/unsigned product of op_a*op_b; {hi_wdata,lo_wdata}=product; both enables=1.
- DIV/DIVU:
  - Restoring radix-2 on magnitudes, one quotient bit per cycle.
  - Signed fix-up: quotient negated if sign(op_a)^sign(op_b); remainder takes the sign of op_a.
  - lo_wdata=quotient, hi_wdata=remainder, both enables=1.
  - Divide by zero (op_b==0): still takes 33 cycles; lo_wdata=32'hFFFFFFFF, hi_wdata=op_a.
- Signed overflow: DIV 32'h80000000 / -1 gives lo=32'h80000000, hi=0.
- flush:
  - In any non-IDLE state, flush returns to IDLE on the next edge.
  - No write pulse is issued, including when flush coincides with the WB cycle: the pulse is suppressed.
  - flush in IDLE blocks acceptance that cycle.
- Mid-operation reset overrides flush and all ops; no write is issued.
- hi_cur/lo_cur are sampled on the accept edge. Only MADD/MSUB use them.

Optional Feature:
- Macro: HILO_MADD_EN
- Defined:
  - MADD/MADDU: {hi,lo} = {hi_cur,lo_cur} + product.
  - MSUB/MSUBU: {hi,lo} = {hi_cur,lo_cur} - product.
  - 64-bit wrap-around arithmetic; same latency as MULT.
- Undefined: codes 0110-1001 are treated as illegal (1-cycle retire, no write); hi_cur/lo_cur are unused.

Test Plan:
- MULT op_a=32'hFFFFFFFE, op_b=3, MUL_CYCLES=2 -> single pulse at T+2 with hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; busy high T+1..T+2.
- DIV op_a=-7, op_b=2 -> pulse at T+33 with lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV op_a=5, op_b=0 -> lo=32'hFFFFFFFF, hi=5 at T+33.
- DIV accepted, flush at T+10 -> no hi_we/lo_we pulse ever; op_ready=1 at T+11; a following MTLO 32'h1234 writes lo=32'h1234 one cycle after its accept.
- MTHI 32'hA5A5A5A5 held valid during a busy DIV -> op_ready=0 and stall_req=1 until the cycle after the DIV write; then accepted, hi_we=1 the next cycle with hi_wdata=32'hA5A5A5A5.
- HILO_MADD_EN defined, hi_cur=0, lo_cur=32'hFFFFFFFF, MADDU 1*1 -> hi=1, lo=0. With the macro undefined, the same op -> no write, op_ready=1 at T+2.
